signal_logger_mc: RTL and testbench

- Parametrised successor to the two-switch logger FSM: captures value changes on NUM_CH debounced inputs into the log FIFO as timestamped records.
- Sits between the debounce bank / command decoder and the log FIFO / UART dump path.
- New relative to the current generation: per-channel enable mask, explicit timestamp-wrap marker records (no forced dump on wrap), saturating dropped-event counter, parametrised auto-dump timeout that returns to STOP.

---
 rtl/signal_logger_mc_pkg.sv | 28 ++
 rtl/signal_logger_mc_if.sv | 32 +++
 rtl/signal_logger_mc_ts_counter.sv | 35 +++
 rtl/signal_logger_mc.sv | 144 ++++++++++++++
 tb/tb_signal_logger_mc.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/signal_logger_mc_pkg.sv
// Shared types and helpers for the multi-channel signal logger.
package signal_logger_mc_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    START = 2'd1,
    STOP  = 2'd2,
    DUMP  = 2'd3
  } state_t;

  localparam int unsigned CLOCK_FREQ_HZ = 50_000_000;

  localparam int unsigned DEF_NUM_CH   = 4;
  localparam int unsigned DEF_TS_WIDTH = 20;

  // Record layout is {marker, timestamp, channel values}; the FIFO width must match.
  function automatic int unsigned rec_width(input int unsigned num_ch,
                                            input int unsigned ts_width);
    return 1 + ts_width + num_ch;
  endfunction

  typedef struct packed {
    logic                    marker;
    logic [DEF_TS_WIDTH-1:0] ts;
    logic [DEF_NUM_CH-1:0]   ch;
  } log_rec_t;

endpackage

// File: rtl/signal_logger_mc_if.sv
// Logger-side bus: channel inputs, command, FIFO write/dump controls and status.
interface signal_logger_mc_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned TS_WIDTH   = 20,
  parameter int unsigned DROP_WIDTH = 8
);
  import signal_logger_mc_pkg::*;

  localparam int unsigned REC_W = rec_width(NUM_CH, TS_WIDTH);

  logic [NUM_CH-1:0]     ch_in;
  logic [NUM_CH-1:0]     ch_enable;
  logic                  log_full;
  state_t                cmd_state;
  logic                  write_en;
  logic [REC_W-1:0]      write_data;
  logic                  read_en;
  logic                  flush;
  state_t                logger_state;
  logic [DROP_WIDTH-1:0] drop_count;

  modport master (
    output ch_in, ch_enable, log_full, cmd_state,
    input  write_en, write_data, read_en, flush, logger_state, drop_count
  );

  modport slave (
    input  ch_in, ch_enable, log_full, cmd_state,
    output write_en, write_data, read_en, flush, logger_state, drop_count
  );

endinterface

// File: rtl/signal_logger_mc_ts_counter.sv
// Free-running timestamp with clear priority and a pulse in the cycle that rolls over.
module logger_ts_counter #(
  parameter int unsigned TS_WIDTH = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_i,
  input  logic                clr_i,
  output logic [TS_WIDTH-1:0] ts_o,
  output logic                wrap_o
);

  logic [TS_WIDTH-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q;
    if (clr_i) begin
      ts_d = '0;
    end else if (inc_i) begin
      ts_d = ts_q + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign ts_o   = ts_q;
  assign wrap_o = inc_i && !clr_i && (&ts_q);

endmodule

// File: rtl/signal_logger_mc.sv
// Edge-triggered timestamped logger with wrap markers, drop counter and timed auto-dump.
module signal_logger_mc
  import signal_logger_mc_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned TS_WIDTH     = 20,
  parameter int unsigned DUMP_TIMEOUT = CLOCK_FREQ_HZ,
  parameter int unsigned DROP_WIDTH   = 8
) (
  input logic               clk,
  input logic               rst,
  signal_logger_mc_if.slave bus
);

  localparam int unsigned TMR_W = $clog2(DUMP_TIMEOUT + 1);

  typedef struct packed {
    logic                marker;
    logic [TS_WIDTH-1:0] ts;
    logic [NUM_CH-1:0]   ch;
  } rec_t;

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [NUM_CH-1:0]     sampled_q;
  logic                  pend_q, pend_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic                  we_q, we_d;
  rec_t                  wd_q, wd_d;
  logic                  re_q, re_d;
  logic                  fl_q, fl_d;

  logic [TS_WIDTH-1:0]   ts_val;
  logic                  ts_wrap, ts_inc, ts_clr;
  logic                  auto_dump;
  logic [NUM_CH-1:0]     change_v;

  assign ts_inc    = (state_q == START) || (state_q == STOP);
  assign ts_clr    = (state_q == CLEAR) || (state_q == DUMP);
  assign auto_dump = (state_q == DUMP) && (timer_q != '0);
  assign change_v  = (bus.ch_in ^ sampled_q) & bus.ch_enable;

  logger_ts_counter #(
    .TS_WIDTH(TS_WIDTH)
  ) u_ts (
    .clk   (clk),
    .rst   (rst),
    .inc_i (ts_inc),
    .clr_i (ts_clr),
    .ts_o  (ts_val),
    .wrap_o(ts_wrap)
  );

  // A nonzero timer marks an auto-dump in progress; a commanded DUMP runs with timer at 0.
  always_comb begin
    state_d = bus.cmd_state;
    timer_d = '0;
    if (auto_dump) begin
      if (timer_q == TMR_W'(DUMP_TIMEOUT)) begin
        state_d = STOP;
      end else begin
        state_d = DUMP;
        timer_d = timer_q + TMR_W'(1);
      end
    end else if ((state_q == START) && bus.log_full) begin
      state_d = DUMP;
      timer_d = TMR_W'(1);
    end
  end

  // The wrap pulse is folded into pending so the marker can go out in the rollover cycle.
  always_comb begin
    we_d   = 1'b0;
    wd_d   = wd_q;
    pend_d = pend_q;
    drop_d = drop_q;
    unique case (state_q)
      START: begin
        pend_d = pend_q | ts_wrap;
        if (change_v != '0) begin
          if (!bus.log_full) begin
            we_d        = 1'b1;
            wd_d.marker = 1'b0;
            wd_d.ts     = ts_val;
            wd_d.ch     = bus.ch_in;
          end else if (drop_q != '1) begin
            drop_d = drop_q + DROP_WIDTH'(1);
          end
        end else if (pend_d && !bus.log_full) begin
          we_d        = 1'b1;
          wd_d.marker = 1'b1;
          wd_d.ts     = '1;
          wd_d.ch     = bus.ch_in;
          pend_d      = 1'b0;
        end
      end
      STOP: begin
      end
      DUMP: begin
        pend_d = 1'b0;
      end
      CLEAR: begin
        pend_d = 1'b0;
        drop_d = '0;
      end
      default: begin
      end
    endcase
    re_d = (state_d == DUMP);
    fl_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      timer_q   <= '0;
      sampled_q <= bus.ch_in;
      pend_q    <= 1'b0;
      drop_q    <= '0;
      we_q      <= 1'b0;
      wd_q      <= '0;
      re_q      <= 1'b0;
      fl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sampled_q <= bus.ch_in;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      we_q      <= we_d;
      wd_q      <= wd_d;
      re_q      <= re_d;
      fl_q      <= fl_d;
    end
  end

  assign bus.logger_state = state_q;
  assign bus.write_en     = we_q;
  assign bus.write_data   = wd_q;
  assign bus.read_en      = re_q;
  assign bus.flush        = fl_q;
  assign bus.drop_count   = drop_q;

endmodule

// File: tb/tb_signal_logger_mc.sv
// Bench for signal_logger_mc: directed scenarios then random traffic against a cycle model.
module tb_signal_logger_mc;
  import signal_logger_mc_pkg::*;

  localparam int unsigned NCH      = 4;
  localparam int unsigned TSW      = 4;
  localparam int unsigned DW       = 2;
  localparam int unsigned TO       = 10;
  localparam int          TS_MOD   = 1 << TSW;
  localparam int          TS_MAX   = TS_MOD - 1;
  localparam int          DROP_MAX = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  signal_logger_mc_if #(.NUM_CH(NCH), .TS_WIDTH(TSW), .DROP_WIDTH(DW)) bus ();

  signal_logger_mc #(
    .NUM_CH(NCH), .TS_WIDTH(TSW), .DUMP_TIMEOUT(TO), .DROP_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  state_t m_state;
  int     m_ts, m_samp, m_pend, m_timer, m_drop, m_wd;
  bit     m_we, m_re, m_fl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    state_t s;
    state_t nxt;
    int nt, chg, ch;
    bit pend;
    s  = m_state;
    ch = int'(bus.ch_in);
    if (rst) begin
      m_state = CLEAR; m_ts = 0; m_timer = 0; m_pend = 0; m_drop = 0;
      m_we = 0; m_wd = 0; m_re = 0; m_fl = 0; m_samp = ch;
      return;
    end
    nt  = 0;
    nxt = bus.cmd_state;
    if (s == DUMP && m_timer != 0) begin
      if (m_timer == TO) nxt = STOP;
      else begin nxt = DUMP; nt = m_timer + 1; end
    end else if (s == START && bus.log_full) begin
      nxt = DUMP; nt = 1;
    end
    m_we = 0;
    case (s)
      START: begin
        chg  = (ch ^ m_samp) & int'(bus.ch_enable);
        pend = (m_pend != 0) || (m_ts == TS_MAX);
        if (chg != 0 && !bus.log_full) begin
          m_we = 1; m_wd = (m_ts << NCH) | ch;
        end else if (chg == 0 && pend && !bus.log_full) begin
          m_we = 1; m_wd = (1 << (TSW + NCH)) | (TS_MAX << NCH) | ch; pend = 0;
        end
        if (chg != 0 && bus.log_full && m_drop < DROP_MAX) m_drop++;
        m_pend = pend;
        m_ts   = (m_ts + 1) % TS_MOD;
      end
      STOP:  m_ts = (m_ts + 1) % TS_MOD;
      DUMP:  begin m_ts = 0; m_pend = 0; end
      CLEAR: begin m_ts = 0; m_pend = 0; m_drop = 0; end
      default: ;
    endcase
    m_samp  = ch;
    m_state = nxt;
    m_timer = nt;
    m_re    = (nxt == DUMP);
    m_fl    = (nxt == CLEAR);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("state", 32'(bus.logger_state), 32'(m_state));
    check("write_en", 32'(bus.write_en), 32'(m_we));
    if (m_we) check("write_data", 32'(bus.write_data), 32'(m_wd));
    check("read_en", 32'(bus.read_en), 32'(m_re));
    check("flush", 32'(bus.flush), 32'(m_fl));
    check("drop_count", 32'(bus.drop_count), 32'(m_drop));
  endtask

  task automatic run_to_ts(input int target);
    for (int i = 0; i < 4 * TS_MOD && m_ts != target; i++) cycle();
  endtask

  initial begin
    logic [NCH-1:0] chv;
    int r;
    rst = 1'b1;
    bus.ch_in = '0; bus.ch_enable = '1; bus.log_full = 1'b0; bus.cmd_state = CLEAR;
    cycle(); cycle();
    check("rst_state", 32'(bus.logger_state), 32'(CLEAR));
    check("rst_we", 32'(bus.write_en), 32'd0);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_drop", 32'(bus.drop_count), 32'd0);

    // Single edge at timestamp 5
    rst = 1'b0; bus.cmd_state = START;
    cycle();
    run_to_ts(5);
    bus.ch_in = 4'b0001;
    cycle();
    check("edge_we", 32'(bus.write_en), 32'd1);
    check("edge_rec", 32'(bus.write_data), 32'h051);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stable_we", 32'(bus.write_en), 32'd0);
    end

    // Enable mask
    bus.ch_enable = 4'b0001; bus.ch_in = 4'b0101;
    cycle();
    check("masked_we", 32'(bus.write_en), 32'd0);
    bus.ch_in = 4'b0100;
    cycle();
    check("mask_we", 32'(bus.write_en), 32'd1);
    chv = bus.write_data[NCH-1:0];
    check("mask_ch", 32'(chv), 32'h4);

    // Wrap marker, then edge coincident with wrap
    bus.ch_enable = '1;
    run_to_ts(TS_MAX);
    cycle();
    check("wrap_we", 32'(bus.write_en), 32'd1);
    check("wrap_rec", 32'(bus.write_data), 32'h1F4);
    cycle();
    check("post_wrap_we", 32'(bus.write_en), 32'd0);
    run_to_ts(TS_MAX);
    bus.ch_in = 4'b0110;
    cycle();
    check("coinc_edge", 32'(bus.write_data), 32'h0F6);
    cycle();
    check("coinc_mk_we", 32'(bus.write_en), 32'd1);
    check("coinc_mk", 32'(bus.write_data), 32'h1F6);

    // FIFO full -> auto-dump, START command ignored until timeout
    bus.ch_in = bus.ch_in ^ 4'b0001; bus.log_full = 1'b1;
    cycle();
    check("ad_state", 32'(bus.logger_state), 32'(DUMP));
    check("ad_read_en", 32'(bus.read_en), 32'd1);
    check("ad_drop", 32'(bus.drop_count), 32'd1);
    for (int i = 0; i < TO - 1; i++) begin
      cycle();
      check("ad_hold", 32'(bus.logger_state), 32'(DUMP));
    end
    cycle();
    check("ad_exit", 32'(bus.logger_state), 32'(STOP));
    for (int k = 0; k < 3; k++) begin
      bus.log_full = 1'b0;
      cycle();
      bus.ch_in = bus.ch_in ^ 4'b1000; bus.log_full = 1'b1;
      cycle();
      for (int i = 0; i < TO; i++) cycle();
    end
    check("drop_sat", 32'(bus.drop_count), 32'(DROP_MAX));

    // CLEAR
    bus.log_full = 1'b0; bus.cmd_state = CLEAR;
    cycle(); cycle();
    check("clr_flush", 32'(bus.flush), 32'd1);
    check("clr_drop", 32'(bus.drop_count), 32'd0);

    // Reset during auto-dump
    bus.cmd_state = START;
    cycle();
    bus.ch_in = bus.ch_in ^ 4'b0010; bus.log_full = 1'b1;
    cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    check("rst_ad_state", 32'(bus.logger_state), 32'(CLEAR));
    check("rst_ad_re", 32'(bus.read_en), 32'd0);
    rst = 1'b0; bus.log_full = 1'b0;
    cycle();
    check("rst_ad_timer", 32'(bus.logger_state), 32'(START));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 300) == 0;
      if (($urandom % 16) == 0) begin
        r = int'($urandom % 32);
        if (r == 0)      bus.cmd_state = CLEAR;
        else if (r == 1) bus.cmd_state = DUMP;
        else if (r < 4)  bus.cmd_state = STOP;
        else             bus.cmd_state = START;
      end
      bus.log_full = ($urandom % 24) == 0;
      if (($urandom % 4) == 0) bus.ch_in = bus.ch_in ^ NCH'($urandom);
      if (($urandom % 32) == 0) bus.ch_enable = NCH'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
